// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshaking on both sides.
// Stage 1 forms per-group (G,P) plus conditional sums for both possible group
// carry-ins. Stage 2 resolves the group carries from c0, selects the sums and
// registers the result flags.
`ifndef GROUPSIZE
`define GROUPSIZE 4
`endif

module cla_pipe_adder #(
    parameter int WIDTH     = 32,
    parameter int GROUPSIZE = `GROUPSIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NGRP = WIDTH / GROUPSIZE;

    // Handshake
    logic s1_valid;
    logic s1_advance;
    logic s2_advance;
    logic in_take;

    assign s2_advance = !out_valid | out_ready;
    assign s1_advance = !s1_valid | s2_advance;
    // Flush blocks acceptance so an input offered during a flush is discarded.
    assign in_ready   = !flush & s1_advance;
    assign in_take    = in_valid & in_ready;

    // Operand preparation
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             c0_nxt;

    assign b_eff  = in_sub ? ~in_b : in_b;
    assign c0_nxt = in_sub ? 1'b1 : in_cin;
    assign gen    = in_a & b_eff;
    assign prop   = in_a ^ b_eff;

    // Stage 1 next-state values
    logic [NGRP-1:0]  grp_g_nxt;
    logic [NGRP-1:0]  grp_p_nxt;
    logic [WIDTH-1:0] sum0_nxt;
    logic [WIDTH-1:0] sum1_nxt;

    // Per-group lookahead: bit carries for both group carry-ins, group G and P
    always_comb begin : group_lookahead
        logic r0;
        logic r1;
        logic rp;
        // NOTE: r0/r1/rp are blocking temporaries chained bit to bit inside one
        // evaluation; they carry no state between evaluations.
        sum0_nxt  = '0;
        sum1_nxt  = '0;
        grp_g_nxt = '0;
        grp_p_nxt = '0;
        r0        = 1'b0;
        r1        = 1'b1;
        rp        = 1'b1;
        for (int gi = 0; gi < NGRP; gi++) begin
            r0 = 1'b0;
            r1 = 1'b1;
            rp = 1'b1;
            for (int bi = 0; bi < GROUPSIZE; bi++) begin
                sum0_nxt[gi*GROUPSIZE+bi] = prop[gi*GROUPSIZE+bi] ^ r0;
                sum1_nxt[gi*GROUPSIZE+bi] = prop[gi*GROUPSIZE+bi] ^ r1;
                r0 = gen[gi*GROUPSIZE+bi] | (prop[gi*GROUPSIZE+bi] & r0);
                r1 = gen[gi*GROUPSIZE+bi] | (prop[gi*GROUPSIZE+bi] & r1);
                rp = rp & prop[gi*GROUPSIZE+bi];
            end
            // The group carry-out with carry-in 0 is exactly the group generate.
            grp_g_nxt[gi] = r0;
            grp_p_nxt[gi] = rp;
        end
    end

    // Stage 1 registers
    logic [NGRP-1:0]  s1_g;
    logic [NGRP-1:0]  s1_p;
    logic [WIDTH-1:0] s1_sum0;
    logic [WIDTH-1:0] s1_sum1;
    logic             s1_c0;
    logic             s1_a_msb;
    logic             s1_b_msb;

    // Stage 1 occupancy: cleared by reset or flush, refilled when it advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 payload: loaded on every accepted input
    // NOTE: payload registers carry no reset; s1_valid qualifies them, so
    // their contents after reset never reach the outputs.
    always_ff @(posedge clk) begin
        if (in_take) begin
            s1_g     <= grp_g_nxt;
            s1_p     <= grp_p_nxt;
            s1_sum0  <= sum0_nxt;
            s1_sum1  <= sum1_nxt;
            s1_c0    <= c0_nxt;
            s1_a_msb <= in_a[WIDTH-1];
            s1_b_msb <= b_eff[WIDTH-1];
        end
    end

    // Stage 2 combinational resolution
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             msb_carry;
    logic             ovf_nxt;
    logic             zero_nxt;

    // Group carry lookahead from c0 and conditional-sum selection
    always_comb begin : carry_resolve
        logic c;
        sum_nxt  = '0;
        c        = s1_c0;
        for (int gi = 0; gi < NGRP; gi++) begin
            sum_nxt[gi*GROUPSIZE +: GROUPSIZE] = c ? s1_sum1[gi*GROUPSIZE +: GROUPSIZE]
                                                   : s1_sum0[gi*GROUPSIZE +: GROUPSIZE];
            c = s1_g[gi] | (s1_p[gi] & c);
        end
        cout_nxt = c;
    end

    // Carry into the MSB is recovered from the MSB sum and operand bits.
    assign msb_carry = sum_nxt[WIDTH-1] ^ s1_a_msb ^ s1_b_msb;
    assign ovf_nxt   = msb_carry ^ cout_nxt;
    assign zero_nxt  = ~|sum_nxt;

    // Output stage: result registers hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_nxt;
                out_cout <= cout_nxt;
                out_ovf  <= ovf_nxt;
                out_zero <= zero_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder: four instances (GROUPSIZE 1, 2, 4, 8)
// share the same stimulus; index 2 (GROUPSIZE 4) drives the handshake checks.
module tb_cla_pipe_adder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_ready;

    logic        rdy [4];
    logic        ov  [4];
    logic [31:0] sm  [4];
    logic        co  [4];
    logic        of  [4];
    logic        zr  [4];

    int total = 0;
    int bad   = 0;

    cla_pipe_adder #(.WIDTH(32), .GROUPSIZE(1)) u_gs1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(ov[0]),
        .out_ready(out_ready), .out_sum(sm[0]), .out_cout(co[0]), .out_ovf(of[0]), .out_zero(zr[0]));
    cla_pipe_adder #(.WIDTH(32), .GROUPSIZE(2)) u_gs2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(ov[1]),
        .out_ready(out_ready), .out_sum(sm[1]), .out_cout(co[1]), .out_ovf(of[1]), .out_zero(zr[1]));
    cla_pipe_adder #(.WIDTH(32), .GROUPSIZE(4)) u_gs4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(ov[2]),
        .out_ready(out_ready), .out_sum(sm[2]), .out_cout(co[2]), .out_ovf(of[2]), .out_zero(zr[2]));
    cla_pipe_adder #(.WIDTH(32), .GROUPSIZE(8)) u_gs8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[3]),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(ov[3]),
        .out_ready(out_ready), .out_sum(sm[3]), .out_cout(co[3]), .out_ovf(of[3]), .out_zero(zr[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
    endtask

    // One isolated operation: accept, check latency, check result on all widths.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
        drive(a, b, cin, sub);
        out_ready = 1'b1;
        #1;
        check({tag, "/in_ready"}, rdy[2], 1);
        step();
        in_valid = 1'b0;
        check({tag, "/lat1"}, ov[2], 0);
        step();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s/gs%0d/valid", tag, 1 << k), ov[k], 1);
            check($sformatf("%s/gs%0d/sum",   tag, 1 << k), sm[k], es);
            check($sformatf("%s/gs%0d/cout",  tag, 1 << k), co[k], ec);
            check($sformatf("%s/gs%0d/ovf",   tag, 1 << k), of[k], eo);
            check($sformatf("%s/gs%0d/zero",  tag, 1 << k), zr[k], ez);
        end
        step();
        check({tag, "/drained"}, ov[2], 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        step();
        check("rst/out_valid", ov[2], 0);
        check("rst/out_sum",   sm[2], 0);
        check("rst/out_zero",  zr[2], 0);
        #3 rst_n = 1'b1;
        step();
        check("rst/in_ready_after", rdy[2], 1);

        // Directed arithmetic vectors
        run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_7_5",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_op("add_cin",    32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("add_negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        run_op("sub_self",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_op("cin_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Backpressure: three back-to-back inputs, consumer stalled for 4 edges
        out_ready = 1'b0;
        drive(32'd1, 32'd2, 1'b0, 1'b0);
        #1 check("bp/rdy_a", rdy[2], 1);
        step();
        drive(32'd10, 32'd20, 1'b0, 1'b0);
        #1 check("bp/rdy_b", rdy[2], 1);
        step();
        drive(32'd100, 32'd200, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("bp/rdy_full%0d", i), rdy[2], 0);
            check($sformatf("bp/hold_valid%0d", i), ov[2], 1);
            check($sformatf("bp/hold_sum%0d", i), sm[2], 32'd3);
            step();
        end
        check("bp/hold_sum_end", sm[2], 32'd3);
        out_ready = 1'b1;
        #1 check("bp/rdy_release", rdy[2], 1);
        step();
        in_valid = 1'b0;
        check("bp/second_valid", ov[2], 1);
        check("bp/second_sum",   sm[2], 32'd30);
        step();
        check("bp/third_valid", ov[2], 1);
        check("bp/third_sum",   sm[2], 32'd300);
        step();
        check("bp/empty", ov[2], 0);

        // Flush with both stages full and an input offered
        out_ready = 1'b0;
        drive(32'h0000_0050, 32'h0000_0005, 1'b0, 1'b0);
        step();
        drive(32'h0000_0060, 32'h0000_0006, 1'b0, 1'b0);
        step();
        check("fl/full_valid", ov[2], 1);
        drive(32'h0000_0070, 32'h0000_0007, 1'b0, 1'b0);
        flush = 1'b1;
        #1 check("fl/in_ready", rdy[2], 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl/out_valid0", ov[2], 0);
        out_ready = 1'b1;
        step();
        check("fl/out_valid1", ov[2], 0);
        step();
        check("fl/out_valid2", ov[2], 0);

        // Asynchronous reset between edges with both stages full
        out_ready = 1'b0;
        drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step();
        drive(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        check("ar/pre_sum",  sm[2], 32'h7FFF_FFFF);
        check("ar/pre_cout", co[2], 1);
        check("ar/pre_ovf",  of[2], 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar/out_valid", ov[2], 0);
        check("ar/out_sum",   sm[2], 0);
        check("ar/out_cout",  co[2], 0);
        check("ar/out_ovf",   of[2], 0);
        check("ar/out_zero",  zr[2], 0);
        #2 rst_n = 1'b1;
        #1 check("ar/in_ready", rdy[2], 1);
        out_ready = 1'b1;
        step();
        check("ar/lost0", ov[2], 0);
        step();
        check("ar/lost1", ov[2], 0);

        run_op("post_reset", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; a multiple of GROUPSIZE, minimum GROUPSIZE.
REQ-002 SHALL have parameter GROUPSIZE, default `GROUPSIZE: lookahead group width; legal values 1, 2, 4, 8.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1: synchronous pipeline clear.
REQ-006 SHALL have port in_valid, input, 1: input operands valid.
REQ-007 SHALL have port in_ready, output, 1: stage 1 can accept this cycle.
REQ-008 SHALL have port in_a, input, WIDTH: operand A.
REQ-009 SHALL have port in_b, input, WIDTH: operand B.
REQ-010 SHALL have port in_cin, input, 1: carry-in; used only when in_sub=0.
REQ-011 SHALL have port in_sub, input, 1: 1 = subtract (A - B), 0 = add (A + B + cin).
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-014 SHALL have port out_sum, output, WIDTH: result.
REQ-015 SHALL have port out_cout, output, 1: carry out of bit WIDTH-1 (subtract: 1 = no borrow).
REQ-016 SHALL have port out_ovf, output, 1: signed overflow.
REQ-017 SHALL have port out_zero, output, 1: out_sum == 0.

Function
REQ-018 Operand prep SHALL be: b_eff = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
REQ-019 Stage 1 SHALL register, per group, the group (G,P) pair plus conditional group sums for group carry-in 0 and 1, bit-level carries rippling by lookahead inside the group; c0 and the bits WIDTH-1 of a and b_eff are also registered.
REQ-020 Stage 2 SHALL resolve group carry-ins by lookahead over the registered group (G,P) pairs from c0, select each group sum, and register out_sum, out_cout, out_ovf, out_zero.
REQ-021 out_ovf SHALL equal carry-into-bit-(WIDTH-1) XOR out_cout.
REQ-022 Transfer SHALL occur at the input when in_valid & in_ready, and at the output when out_valid & out_ready.
REQ-023 Each stage SHALL advance when it is empty or its downstream stage advances in the same cycle; in_ready = !s1_valid | s1_advance, combinational from out_ready, no combinational path from in_valid.
REQ-024 Latency SHALL be exactly 2 cycles from input transfer to out_valid when unstalled; throughput 1 result/cycle.
REQ-025 While out_valid & !out_ready, all out_* SHALL hold stable; no result SHALL be dropped, duplicated or reordered.
REQ-026 With both stages full and out_ready=0, in_ready SHALL be 0.
REQ-027 flush=1 SHALL clear both stage valid bits at the next edge, force in_ready=0 that cycle, and discard any input offered; flush beats simultaneous input and output transfer.
REQ-028 For GROUPSIZE=1 the group (G,P) SHALL be the bit (g,p); the result SHALL be bit-identical for every legal GROUPSIZE.

Reset
REQ-029 rst_n=0 SHALL immediately clear both stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero to 0, regardless of clock.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts; in-flight operations at reset assertion SHALL be lost.

Verification (WIDTH=32, GROUPSIZE=4 unless stated)
REQ-031 Add a=0xFFFFFFFF b=0x1 cin=0 -> 2 cycles later sum=0x00000000, cout=1, ovf=0, zero=1.
REQ-032 Add a=0x7FFFFFFF b=0x1 cin=0 -> sum=0x80000000, cout=0, ovf=1, zero=0; repeat for GROUPSIZE 1, 2, 8 with identical results.
REQ-033 Sub a=5 b=7 (cin=1 ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0; sub a=7 b=5 -> sum=0x2, cout=1.
REQ-034 Three back-to-back inputs with out_ready=0 for 4 cycles -> in_ready=0 after two accepted, third held; results then emitted in order, none lost.
REQ-035 flush with both stages full and in_valid=1 -> out_valid=0 next cycle, offered input not emitted.
REQ-036 rst_n pulsed low between clock edges with both stages full -> out_valid and all outputs 0 immediately; in_ready=1 after release.
